// File: rtl/arr_pkg.sv
// Shared widths for the 4x4 weight-stationary MAC array.
// Imported by the interface, the PE and the top level.
package arr_pkg;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int PROD_W = 2 * DATA_W;
endpackage

// File: rtl/arr_if.sv
// Edge bus of the array: fault flags, hold, weight/activation
// inputs and the bottom/right edge register taps.
interface arr_if;
  import arr_pkg::*;

  logic              Err_mac;
  logic              Err_mult;
  logic              hold;
  logic [DATA_W-1:0] w1_in;
  logic [DATA_W-1:0] w2_in;
  logic [DATA_W-1:0] w3_in;
  logic [DATA_W-1:0] w4_in;
  logic [DATA_W-1:0] a1_in;
  logic [DATA_W-1:0] a2_in;
  logic [DATA_W-1:0] a3_in;
  logic [DATA_W-1:0] a4_in;
  logic [DATA_W-1:0] w1_out;
  logic [DATA_W-1:0] w2_out;
  logic [DATA_W-1:0] w3_out;
  logic [DATA_W-1:0] w4_out;
  logic [DATA_W-1:0] a1_out;
  logic [DATA_W-1:0] a2_out;
  logic [DATA_W-1:0] a3_out;
  logic [DATA_W-1:0] a4_out;
  logic [ACC_W-1:0]  c1_out;
  logic [ACC_W-1:0]  c2_out;
  logic [ACC_W-1:0]  c3_out;
  logic [ACC_W-1:0]  c4_out;

  modport master (
    output Err_mac, Err_mult, hold,
    output w1_in, w2_in, w3_in, w4_in,
    output a1_in, a2_in, a3_in, a4_in,
    input  w1_out, w2_out, w3_out, w4_out,
    input  a1_out, a2_out, a3_out, a4_out,
    input  c1_out, c2_out, c3_out, c4_out
  );

  modport slave (
    input  Err_mac, Err_mult, hold,
    input  w1_in, w2_in, w3_in, w4_in,
    input  a1_in, a2_in, a3_in, a4_in,
    output w1_out, w2_out, w3_out, w4_out,
    output a1_out, a2_out, a3_out, a4_out,
    output c1_out, c2_out, c3_out, c4_out
  );
endinterface

// File: rtl/arr_pe.sv
// One MAC cell: weight, activation and partial-sum registers.
// Ports: w_up/a_left/p_up from neighbours, *_q register taps out.
module arr_pe
  import arr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              err_mac,
  input  logic              err_mult,
  input  logic [DATA_W-1:0] w_up,
  input  logic [DATA_W-1:0] a_left,
  input  logic [ACC_W-1:0]  p_up,
  output logic [DATA_W-1:0] w_q,
  output logic [DATA_W-1:0] a_q,
  output logic [ACC_W-1:0]  p_q
);

  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] a_d;
  logic [ACC_W-1:0]  p_d;
  logic [PROD_W-1:0] prod_raw;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;

  // Fault flips: product bit 0 before the add, sum bit 0 after.
  always_comb begin
    prod_raw = a_left * w_q;
    prod     = {prod_raw[PROD_W-1:1], prod_raw[0] ^ err_mult};
    sum      = p_up + ACC_W'(prod);
    p_d      = {sum[ACC_W-1:1], sum[0] ^ err_mac};
    a_d      = a_left;
    w_d      = hold ? w_q : w_up;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      a_q <= '0;
      p_q <= '0;
    end else begin
      w_q <= w_d;
      a_q <= a_d;
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/arr_4x4.sv
// 4x4 weight-stationary systolic MAC array top level.
// Ports: arr_if slave bus (edges), clk, async active-low rst_n.
module arr_4x4
  import arr_pkg::*;
(
  arr_if.slave bus,
  input logic  clk,
  input logic  rst_n
);

  logic [DATA_W-1:0] w_in [N];
  logic [DATA_W-1:0] a_in [N];
  logic [DATA_W-1:0] w_q  [N][N];
  logic [DATA_W-1:0] a_q  [N][N];
  logic [ACC_W-1:0]  p_q  [N][N];

  assign w_in[0] = bus.w1_in;
  assign w_in[1] = bus.w2_in;
  assign w_in[2] = bus.w3_in;
  assign w_in[3] = bus.w4_in;
  assign a_in[0] = bus.a1_in;
  assign a_in[1] = bus.a2_in;
  assign a_in[2] = bus.a3_in;
  assign a_in[3] = bus.a4_in;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [DATA_W-1:0] w_up;
      logic [DATA_W-1:0] a_left;
      logic [ACC_W-1:0]  p_up;

      if (r == 0) begin : g_top
        assign w_up = w_in[c];
        assign p_up = '0;
      end else begin : g_inner
        assign w_up = w_q[r-1][c];
        assign p_up = p_q[r-1][c];
      end

      if (c == 0) begin : g_left
        assign a_left = a_in[r];
      end else begin : g_right
        assign a_left = a_q[r][c-1];
      end

      arr_pe u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (bus.hold),
        .err_mac  (bus.Err_mac),
        .err_mult (bus.Err_mult),
        .w_up     (w_up),
        .a_left   (a_left),
        .p_up     (p_up),
        .w_q      (w_q[r][c]),
        .a_q      (a_q[r][c]),
        .p_q      (p_q[r][c])
      );
    end
  end

  assign bus.w1_out = w_q[N-1][0];
  assign bus.w2_out = w_q[N-1][1];
  assign bus.w3_out = w_q[N-1][2];
  assign bus.w4_out = w_q[N-1][3];
  assign bus.a1_out = a_q[0][N-1];
  assign bus.a2_out = a_q[1][N-1];
  assign bus.a3_out = a_q[2][N-1];
  assign bus.a4_out = a_q[3][N-1];
  assign bus.c1_out = p_q[N-1][0];
  assign bus.c2_out = p_q[N-1][1];
  assign bus.c3_out = p_q[N-1][2];
  assign bus.c4_out = p_q[N-1][3];

endmodule

// File: tb/tb_arr_4x4.sv
// Directed bench for arr_4x4: load/hold, dot products,
// passthrough, reset, wide values and fault injection.
module tb_arr_4x4;
  import arr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  arr_if u_if ();

  arr_4x4 dut (
    .bus   (u_if),
    .clk   (clk),
    .rst_n (rst_n)
  );

  wire [7:0]  w_o [4];
  wire [7:0]  a_o [4];
  wire [23:0] c_o [4];

  assign w_o[0] = u_if.w1_out;
  assign w_o[1] = u_if.w2_out;
  assign w_o[2] = u_if.w3_out;
  assign w_o[3] = u_if.w4_out;
  assign a_o[0] = u_if.a1_out;
  assign a_o[1] = u_if.a2_out;
  assign a_o[2] = u_if.a3_out;
  assign a_o[3] = u_if.a4_out;
  assign c_o[0] = u_if.c1_out;
  assign c_o[1] = u_if.c2_out;
  assign c_o[2] = u_if.c3_out;
  assign c_o[3] = u_if.c4_out;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [7:0] w1, w2, w3, w4);
    u_if.w1_in = w1;
    u_if.w2_in = w2;
    u_if.w3_in = w3;
    u_if.w4_in = w4;
  endtask

  task automatic set_a(input logic [7:0] a1, a2, a3, a4);
    u_if.a1_in = a1;
    u_if.a2_in = a2;
    u_if.a3_in = a3;
    u_if.a4_in = a4;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] seq(input int i);
    return (i >= 0 && i < 8) ? 8'(8 - i) : 8'd0;
  endfunction

  task automatic test_reset;
    u_if.Err_mac  = 1'b0;
    u_if.Err_mult = 1'b0;
    u_if.hold     = 1'b0;
    set_w(8'd0, 8'd0, 8'd0, 8'd0);
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
    rst_n = 1'b0;
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (w_o[j] !== 8'd0 || a_o[j] !== 8'd0 || c_o[j] !== 24'd0) begin
        $display("FAIL reset_state col%0d: w=%0d a=%0d c=%0d want 0",
                 j + 1, w_o[j], a_o[j], c_o[j]);
        fails++;
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_weight_load;
    logic [7:0] exp_w [4];
    exp_w = '{8'd4, 8'd3, 8'd2, 8'd1};
    u_if.hold = 1'b0;
    set_w(8'd4, 8'd3, 8'd2, 8'd1);
    tick();
    set_w(8'd8, 8'd7, 8'd6, 8'd5);
    tick();
    set_w(8'd4, 8'd3, 8'd2, 8'd1);
    tick();
    set_w(8'd8, 8'd7, 8'd6, 8'd5);
    tick();
    u_if.hold = 1'b1;
    set_w(8'd99, 8'd99, 8'd99, 8'd99);
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (w_o[j] !== exp_w[j]) begin
        $display("FAIL weight_load w%0d_out: got %0d want %0d",
                 j + 1, w_o[j], exp_w[j]);
        fails++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      tests++;
      if (w_o[0] !== 8'd4 || w_o[1] !== 8'd3 ||
          w_o[2] !== 8'd2 || w_o[3] !== 8'd1) begin
        $display("FAIL weight_hold edge %0d: got %0d,%0d,%0d,%0d want 4,3,2,1",
                 k, w_o[0], w_o[1], w_o[2], w_o[3]);
        fails++;
      end
    end
  endtask

  // Column weight sums with rows (8,7,6,5),(4,3,2,1) repeated.
  task automatic test_dot_product;
    int colsum [4];
    int i;
    logic [23:0] exp_c;
    logic [7:0]  exp_a;
    colsum = '{24, 20, 16, 12};
    for (int k = 0; k < 20; k++) begin
      set_a(seq(k), seq(k - 1), seq(k - 2), seq(k - 3));
      tick();
      for (int j = 0; j < 4; j++) begin
        i = k - 3 - j;
        exp_c = 24'(int'(seq(i)) * colsum[j]);
        tests++;
        if (c_o[j] !== exp_c) begin
          $display("FAIL dot c%0d_out edge %0d: got %0d want %0d",
                   j + 1, k, c_o[j], exp_c);
          fails++;
        end
        exp_a = seq(k - 3 - j);
        tests++;
        if (a_o[j] !== exp_a) begin
          $display("FAIL dot a%0d_out edge %0d: got %0d want %0d",
                   j + 1, k, a_o[j], exp_a);
          fails++;
        end
      end
    end
  endtask

  task automatic test_passthrough;
    set_a(8'h5A, 8'd0, 8'd0, 8'd0);
    tick();
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    tests++;
    if (a_o[0] !== 8'h00) begin
      $display("FAIL pass_early a1_out: got %0h want 0", a_o[0]);
      fails++;
    end
    tick();
    tests++;
    if (a_o[0] !== 8'h5A) begin
      $display("FAIL pass_edge4 a1_out: got %0h want 5a", a_o[0]);
      fails++;
    end
    tick();
    tests++;
    if (a_o[0] !== 8'h00) begin
      $display("FAIL pass_late a1_out: got %0h want 0", a_o[0]);
      fails++;
    end
  endtask

  task automatic test_reset_mid;
    set_a(8'd9, 8'd9, 8'd9, 8'd9);
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (w_o[j] !== 8'd0 || a_o[j] !== 8'd0 || c_o[j] !== 24'd0) begin
        $display("FAIL reset_mid col%0d: w=%0d a=%0d c=%0d want 0",
                 j + 1, w_o[j], a_o[j], c_o[j]);
        fails++;
      end
    end
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (w_o[0] !== 8'd0 || w_o[3] !== 8'd0) begin
      $display("FAIL reset_weights_cleared: w1=%0d w4=%0d want 0",
               w_o[0], w_o[3]);
      fails++;
    end
  endtask

  task automatic test_wide_values;
    u_if.hold = 1'b0;
    set_w(8'd255, 8'd255, 8'd255, 8'd255);
    for (int k = 0; k < 4; k++) tick();
    u_if.hold = 1'b1;
    set_a(8'd255, 8'd255, 8'd255, 8'd255);
    for (int k = 0; k < 9; k++) tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (c_o[j] !== 24'd260100) begin
        $display("FAIL wide c%0d_out: got %0d want 260100",
                 j + 1, c_o[j]);
        fails++;
      end
    end
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  // Only PE(1,1) has a nonzero weight; a1 held at 1.
  task automatic test_err_mult;
    logic [23:0] exp_n [4];
    logic [23:0] exp_f [4];
    exp_n = '{24'd1, 24'd0, 24'd0, 24'd0};
    exp_f = '{24'd3, 24'd4, 24'd4, 24'd4};
    do_reset();
    u_if.hold = 1'b0;
    set_w(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    tick();
    set_w(8'd1, 8'd0, 8'd0, 8'd0);
    tick();
    u_if.hold = 1'b1;
    set_a(8'd1, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (c_o[j] !== exp_n[j]) begin
        $display("FAIL mult_clean c%0d_out: got %0d want %0d",
                 j + 1, c_o[j], exp_n[j]);
        fails++;
      end
    end
    u_if.Err_mult = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (c_o[j] !== exp_f[j]) begin
        $display("FAIL mult_fault c%0d_out: got %0d want %0d",
                 j + 1, c_o[j], exp_f[j]);
        fails++;
      end
    end
    u_if.Err_mult = 1'b0;
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  // From a cleared array every sum flips to 1 on the first edge.
  task automatic test_err_mac;
    set_w(8'd0, 8'd0, 8'd0, 8'd0);
    set_a(8'd0, 8'd0, 8'd0, 8'd0);
    do_reset();
    u_if.Err_mac = 1'b1;
    tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (c_o[j] !== 24'd1) begin
        $display("FAIL mac_edge1 c%0d_out: got %0d want 1",
                 j + 1, c_o[j]);
        fails++;
      end
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (c_o[j] !== 24'd0) begin
        $display("FAIL mac_edge2 c%0d_out: got %0d want 0",
                 j + 1, c_o[j]);
        fails++;
      end
    end
    u_if.Err_mac = 1'b0;
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_dot_product();
    test_passthrough();
    test_reset_mid();
    test_wide_values();
    test_err_mult();
    test_err_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
